// File: rtl/cache_ctrl.sv
// Sequencing controller for a direct-mapped, read-only cache: tag/valid ownership,
// hit lookup against a synchronous data array, and word-by-word line refill from memory.
module cache_ctrl #(
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [31:0]         req_addr,
    output logic                rsp_valid,
    output logic                rsp_hit,
    output logic [31:0]         rsp_data,
    input  logic                flush,
    output logic                busy,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [31:0]         mem_req_addr,
    input  logic                mem_rsp_valid,
    input  logic [31:0]         mem_rsp_data,
    output logic                dary_we,
    output logic [INDEX_W-1:0]  dary_index,
    output logic [OFFSET_W-1:0] dary_word,
    output logic [31:0]         dary_wdata,
    input  logic [31:0]         dary_rdata,
    output logic [15:0]         hit_count,
    output logic [15:0]         miss_count
);

    localparam int TAG_W   = 32 - INDEX_W - OFFSET_W - 2;
    localparam int LINES   = 1 << INDEX_W;
    localparam int IDX_LO  = OFFSET_W + 2;
    localparam int TAG_LO  = INDEX_W + OFFSET_W + 2;

    // Handshakes: a transfer happens on the rising edge where valid and ready are both high;
    // a valid request holds its payload stable until that edge.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL_REQ,
        S_REFILL_WAIT,
        S_RESPOND,
        S_FLUSH
    } state_e;

    state_e              state_q, state_d;
    logic [31:2]         addr_q, addr_d;
    logic [OFFSET_W-1:0] cnt_q, cnt_d;
    logic [INDEX_W-1:0]  fidx_q, fidx_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic                rsp_hit_q, rsp_hit_d;
    logic [31:0]         rsp_word_q, rsp_word_d;
    logic [15:0]         hit_count_q, hit_count_d;
    logic [15:0]         miss_count_q, miss_count_d;
    logic [TAG_W-1:0]    tag_q [LINES];

    logic [INDEX_W-1:0]  a_index;
    logic [OFFSET_W-1:0] a_word;
    logic [TAG_W-1:0]    a_tag;
    logic                lookup_hit;
    logic                refill_beat;
    logic                refill_last;
    logic                tag_we;
    logic                unused_addr_bits;

    assign a_index     = addr_q[TAG_LO-1:IDX_LO];
    assign a_word      = addr_q[IDX_LO-1:2];
    assign a_tag       = addr_q[31:TAG_LO];
    assign lookup_hit  = valid_q[a_index] && (tag_q[a_index] == a_tag);
    assign refill_beat = (state_q == S_REFILL_WAIT) && mem_rsp_valid;
    assign refill_last = refill_beat && (&cnt_q);
    assign tag_we      = refill_last;
    assign unused_addr_bits = ^req_addr[1:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (flush) begin
                    state_d = S_FLUSH;
                end else if (req_valid) begin
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP:      state_d = lookup_hit ? S_RESPOND : S_REFILL_REQ;
            S_REFILL_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_REFILL_WAIT;
                end
            end
            S_REFILL_WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = (&cnt_q) ? S_RESPOND : S_REFILL_REQ;
                end
            end
            S_RESPOND:     state_d = S_IDLE;
            S_FLUSH: begin
                if (&fidx_q) begin
                    state_d = S_IDLE;
                end
            end
            default:       state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready     = 1'b0;
        busy          = (state_q != S_IDLE);
        rsp_valid     = 1'b0;
        rsp_hit       = 1'b0;
        rsp_data      = '0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        dary_we       = 1'b0;
        dary_index    = '0;
        dary_word     = '0;
        dary_wdata    = '0;
        unique case (state_q)
            S_IDLE: req_ready = ~flush;
            S_LOOKUP: begin
                dary_index = a_index;
                dary_word  = a_word;
            end
            S_REFILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {addr_q[31:IDX_LO], cnt_q, 2'b00};
                dary_index    = a_index;
            end
            S_REFILL_WAIT: begin
                dary_we    = mem_rsp_valid;
                dary_index = a_index;
                dary_word  = cnt_q;
                dary_wdata = mem_rsp_valid ? mem_rsp_data : '0;
            end
            S_RESPOND: begin
                rsp_valid  = 1'b1;
                rsp_hit    = rsp_hit_q;
                // A hit reads the array registered in LOOKUP; a refill answers from the captured word.
                rsp_data   = rsp_hit_q ? dary_rdata : rsp_word_q;
                dary_index = a_index;
                dary_word  = a_word;
            end
            default: ;
        endcase
    end

    // Datapath next values
    always_comb begin
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        fidx_d       = fidx_q;
        valid_d      = valid_q;
        rsp_hit_d    = rsp_hit_q;
        rsp_word_d   = rsp_word_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        unique case (state_q)
            S_IDLE: begin
                if (flush) begin
                    fidx_d = '0;
                end else if (req_valid) begin
                    addr_d = req_addr[31:2];
                end
            end
            S_LOOKUP: begin
                rsp_hit_d = lookup_hit;
                if (lookup_hit) begin
                    hit_count_d = (&hit_count_q) ? hit_count_q : hit_count_q + 16'd1;
                end else begin
                    cnt_d        = '0;
                    miss_count_d = (&miss_count_q) ? miss_count_q : miss_count_q + 16'd1;
                end
            end
            S_REFILL_WAIT: begin
                if (refill_beat) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == a_word) begin
                        rsp_word_d = mem_rsp_data;
                    end
                end
                // The line only becomes valid once every word is in the array.
                if (refill_last) begin
                    valid_d[a_index] = 1'b1;
                end
            end
            S_FLUSH: begin
                valid_d[fidx_q] = 1'b0;
                fidx_d          = fidx_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            cnt_q        <= '0;
            fidx_q       <= '0;
            valid_q      <= '0;
            rsp_hit_q    <= 1'b0;
            rsp_word_q   <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            fidx_q       <= fidx_d;
            valid_q      <= valid_d;
            rsp_hit_q    <= rsp_hit_d;
            rsp_word_q   <= rsp_word_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    // Tags are plain storage: meaningless until the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[a_index] <= a_tag;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: memory and data-array models, a transaction-level cache model
// feeding an expected-response queue, and a per-cycle compare process.
module tb_cache_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_hit;
    logic [31:0] rsp_data;
    logic        flush;
    logic        busy;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        dary_we;
    logic [7:0]  dary_index;
    logic [3:0]  dary_word;
    logic [31:0] dary_wdata;
    logic [31:0] dary_rdata;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    cache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_data(rsp_data),
        .flush(flush), .busy(busy),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .dary_we(dary_we), .dary_index(dary_index), .dary_word(dary_word),
        .dary_wdata(dary_wdata), .dary_rdata(dary_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Scoreboard: {expected response cycle, hit, data}
    logic [64:0] exp_q[$];
    logic [31:0] exp_mem_q[$];
    logic [31:0] mem_log[$];

    // Cache model at line granularity
    logic        mvalid [256];
    logic [17:0] mtag [256];
    logic [15:0] mhits;
    logic [15:0] mmiss;

    logic [31:0] dmem [4096];
    logic [31:0] last_data;
    logic        last_hit;
    int          hs_count = 0;
    int          stall_word = -1;
    int          stall_left = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event did not occur as required (t=%0t)", name, $time);
    endtask

    // Clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Memory and synchronous data-array models
    initial begin
        logic        hs;
        logic [31:0] hs_addr;
        logic [11:0] rd_a;
        logic        wr;
        logic [31:0] wd;
        forever begin
            @(negedge clk);
            hs      = mem_req_valid && mem_req_ready;
            hs_addr = mem_req_addr;
            if (hs) begin
                mem_log.push_back(hs_addr);
                hs_count++;
            end
            rd_a = {dary_index, dary_word};
            wr   = dary_we;
            wd   = dary_wdata;
            @(posedge clk);
            #1;
            dary_rdata = dmem[rd_a];
            if (wr) dmem[rd_a] = wd;
            mem_rsp_valid = hs && rst_n;
            mem_rsp_data  = hs ? mem_word(hs_addr) : 32'h0;
            if (mem_req_valid && stall_word >= 0 && int'(mem_req_addr[5:2]) == stall_word
                && stall_left > 0) begin
                mem_req_ready = 1'b0;
                stall_left--;
            end else begin
                mem_req_ready = 1'b1;
            end
        end
    end

    // Compare process
    always @(negedge clk) begin
        logic [64:0] e;
        if (rst_n) begin
            if (busy) check("busy_req_ready", {31'b0, req_ready}, 32'h0);
            if (mem_req_valid) begin
                if (exp_mem_q.size() == 0) begin
                    fail_now("mem_req_unexpected");
                end else begin
                    check("mem_req_addr", mem_req_addr, exp_mem_q[0]);
                    if (mem_req_ready) void'(exp_mem_q.pop_front());
                end
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("rsp_unexpected");
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_hit", {31'b0, rsp_hit}, {31'b0, e[32]});
                    check("rsp_data", rsp_data, e[31:0]);
                    check("rsp_cycle", cyc, e[64:33]);
                    check("hit_count", {16'h0, hit_count}, {16'h0, mhits});
                    check("miss_count", {16'h0, miss_count}, {16'h0, mmiss});
                    last_data = rsp_data;
                    last_hit  = rsp_hit;
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
        mhits = '0;
        mmiss = '0;
        exp_q.delete();
        exp_mem_q.delete();
    endtask

    task automatic check_reset_outs();
        check("rst_req_ready", {31'b0, req_ready}, 32'h1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_rsp_hit", {31'b0, rsp_hit}, 32'h0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'h0);
        check("rst_mem_req_addr", mem_req_addr, 32'h0);
        check("rst_dary_we", {31'b0, dary_we}, 32'h0);
        check("rst_dary_index", {24'h0, dary_index}, 32'h0);
        check("rst_dary_word", {28'h0, dary_word}, 32'h0);
        check("rst_dary_wdata", dary_wdata, 32'h0);
        check("rst_hit_count", {16'h0, hit_count}, 32'h0);
        check("rst_miss_count", {16'h0, miss_count}, 32'h0);
    endtask

    // Driver: issue one read, predict its outcome, optionally wait for the response
    task automatic do_read(input logic [31:0] addr, input int stall_w, input int stall_n,
                           input bit wait_rsp);
        int          t;
        int          acc;
        int          lat;
        logic [7:0]  idx;
        logic [17:0] tg;
        logic        hit;
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_addr   = addr;
        stall_word = stall_w;
        stall_left = stall_n;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) fail_now("accept_timeout");
        acc = cyc;
        idx = addr[13:6];
        tg  = addr[31:14];
        hit = mvalid[idx] && (mtag[idx] == tg);
        if (hit) begin
            if (mhits != 16'hFFFF) mhits = mhits + 16'd1;
            lat = 2;
        end else begin
            if (mmiss != 16'hFFFF) mmiss = mmiss + 16'd1;
            for (int w = 0; w < 16; w++) exp_mem_q.push_back({addr[31:6], 4'(w), 2'b00});
            mvalid[idx] = 1'b1;
            mtag[idx]   = tg;
            lat = 34 + stall_n;
        end
        exp_q.push_back({32'(acc + lat), hit, mem_word({addr[31:2], 2'b00})});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (wait_rsp) begin
            t = 0;
            while (exp_q.size() != 0 && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (exp_q.size() != 0) begin
                fail_now("rsp_timeout");
                exp_q.delete();
                exp_mem_q.delete();
            end
        end
    endtask

    initial begin
        int n;
        int base;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_addr = '0;
        flush = 1'b0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data = '0;
        dary_rdata = '0;
        last_data = '0;
        last_hit = 1'b0;
        model_reset();
        #12;
        check_reset_outs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Cold miss with full refill
        mem_log.delete();
        do_read(32'h0000_4048, -1, 0, 1);
        check("miss1_mem_reqs", mem_log.size(), 32'd16);
        check("miss1_first_addr", mem_log[0], 32'h0000_4040);
        check("miss1_last_addr", mem_log[15], 32'h0000_407C);
        check("miss1_data", last_data, 32'h4048_BFB7);
        check("miss1_hit", {31'b0, last_hit}, 32'h0);
        check("miss1_count", {16'h0, miss_count}, 32'd1);

        // Repeat read hits
        do_read(32'h0000_4048, -1, 0, 1);
        check("hit1_hit", {31'b0, last_hit}, 32'h1);
        check("hit1_data", last_data, 32'h4048_BFB7);
        check("hit1_count", {16'h0, hit_count}, 32'd1);

        // Conflict on the same index, then eviction of the original line
        do_read(32'h0000_8048, -1, 0, 1);
        check("conf_data", last_data, 32'h8048_7FB7);
        check("conf_hit", {31'b0, last_hit}, 32'h0);
        do_read(32'h0000_4048, -1, 0, 1);
        check("evict_hit", {31'b0, last_hit}, 32'h0);
        check("evict_miss_count", {16'h0, miss_count}, 32'd3);

        // Memory back-pressure on word 7 of the refill
        mem_log.delete();
        do_read(32'h1234_5678, 7, 5, 1);
        check("stall_data", last_data, 32'h5678_A987);
        check("stall_mem_reqs", mem_log.size(), 32'd16);
        do_read(32'h1234_567C, -1, 0, 1);
        check("stall_hit_w15", last_data, 32'h567C_A983);
        do_read(32'h1234_5640, -1, 0, 1);
        check("stall_hit_w0", last_data, 32'h5640_A9BF);

        // Flush
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_idle_ready", {31'b0, req_ready}, 32'h0);
        check("flush_idle_busy", {31'b0, busy}, 32'h0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        n = 0;
        @(negedge clk);
        while (busy && n < 400) begin
            n++;
            @(negedge clk);
        end
        check("flush_busy_cycles", n, 32'd256);
        for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
        do_read(32'h0000_4048, -1, 0, 1);
        check("post_flush_hit", {31'b0, last_hit}, 32'h0);

        // Reset in the middle of a refill
        base = hs_count;
        do_read(32'h0000_C048, -1, 0, 0);
        n = 0;
        while (hs_count < base + 10 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (hs_count < base + 10) fail_now("refill_progress_timeout");
        #2;
        check("pre_reset_we", {31'b0, dary_we}, 32'h1);
        check("pre_reset_word", {28'h0, dary_word}, 32'd9);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_read(32'h0000_C048, -1, 0, 1);
        check("after_reset_hit", {31'b0, last_hit}, 32'h0);
        check("after_reset_data", last_data, 32'hC048_3FB7);
        check("after_reset_miss_count", {16'h0, miss_count}, 32'd1);

        repeat (3) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 32'd0);
        check("exp_mem_q_drained", exp_mem_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
